nios2_debug_ocimem_sequencer: RTL and testbench

System-clock-domain controller that sequences the CPU's on-chip debug memory (OCI RAM) on behalf of the JTAG debug slave. It accepts debugger commands delivered as a TCK-domain toggle plus a stable 38-bit data register, synchronises them, and decodes set-address, write, read and peek operations. It then drives a single-master waitrequest memory handshake with address auto-increment and a timeout. Results are returned in a monitor data register readable by the debug scan chain.

---
 rtl/nios2_debug_ocimem_sequencer.sv | 135 +++++++++++++
 tb/tb_nios2_debug_ocimem_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_ocimem_sequencer.sv
// Sequences OCI debug memory accesses for the JTAG debug slave: synchronises
// the TCK-domain command toggle, decodes the command and runs a timed handshake.
module nios2_debug_ocimem_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_udr_toggle,
    input  logic [1:0]        ir_in,
    input  logic [37:0]       jdo,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mon_dreg,
    output logic              mon_ready,
    output logic              busy,
    output logic              error
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] OP_SETADDR = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;

    typedef enum logic [1:0] {IDLE, DEC, WR, RD} state_t;

    state_t             state, state_next;
    logic               sync1, sync2, sync3;
    logic               cmd_pulse;
    logic [1:0]         cmd_op;
    logic [31:0]        cmd_data;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               accept, overrun, done, tmo;
    logic               unused_jdo;

    assign cmd_pulse  = sync2 ^ sync3;
    assign unused_jdo = ^jdo[35:32];

    // Next-state and transfer-event decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        overrun    = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        if (cmd_pulse && ir_in == 2'b00) begin
            if (state == IDLE) accept  = 1'b1;
            else               overrun = 1'b1;
        end
        case (state)
            IDLE: if (accept) state_next = DEC;
            DEC: begin
                case (cmd_op)
                    OP_SETADDR: state_next = IDLE;
                    OP_WRITE:   state_next = WR;
                    default:    state_next = RD;
                endcase
            end
            WR, RD: begin
                if (!mem_waitrequest) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, synchroniser and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            cmd_op    <= 2'b00;
            cmd_data  <= 32'h0;
            tmo_cnt   <= '0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mon_dreg  <= 32'h0;
            mon_ready <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            sync1     <= jtag_udr_toggle;
            sync2     <= sync1;
            sync3     <= sync2;
            state     <= state_next;
            busy      <= (state_next != IDLE);
            mem_write <= (state_next == WR);
            mem_read  <= (state_next == RD);

            if (accept) begin
                cmd_op    <= jdo[37:36];
                cmd_data  <= jdo[31:0];
                mon_ready <= 1'b0;
            end

            if (state == DEC) begin
                tmo_cnt <= '0;
                if (cmd_op == OP_SETADDR) begin
                    mem_addr <= cmd_data[ADDR_W-1:0];
                    error    <= 1'b0;
                end
                if (cmd_op == OP_WRITE) mem_wdata <= cmd_data;
            end

            if ((state == WR || state == RD) && mem_waitrequest && !tmo)
                tmo_cnt <= tmo_cnt + CNT_W'(1);

            if (done) begin
                if (state == WR || cmd_op == OP_READ)
                    mem_addr <= mem_addr + ADDR_W'(1);
                if (state == RD) begin
                    mon_dreg  <= mem_rdata;
                    mon_ready <= 1'b1;
                end
            end

            // Error set takes priority over a same-cycle SETADDR clear
            if (tmo || overrun) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios2_debug_ocimem_sequencer.sv
// Directed bench for the OCI memory sequencer: bus monitor, stall generator
// and a linear list of debugger commands with hand-computed expectations.
module tb_nios2_debug_ocimem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        jtag_udr_toggle;
    logic [1:0]  ir_in;
    logic [37:0] jdo;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_rdata;
    logic [31:0] mon_dreg;
    logic        mon_ready;
    logic        busy;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;

    int          wr_cycles = 0;
    int          rd_cycles = 0;
    int          both_high = 0;
    logic [7:0]  last_wr_addr = 8'h0;
    logic [31:0] last_wr_data = 32'h0;
    int          stall_target = 0;
    int          stall_cnt = 0;
    int          wr_base, rd_base;

    nios2_debug_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .jtag_udr_toggle (jtag_udr_toggle),
        .ir_in           (ir_in),
        .jdo             (jdo),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_waitrequest (mem_waitrequest),
        .mem_rdata       (mem_rdata),
        .mon_dreg        (mon_dreg),
        .mon_ready       (mon_ready),
        .busy            (busy),
        .error           (error)
    );

    always #5 clk = ~clk;

    // Bus monitor: counts request cycles and records write address/data
    always @(posedge clk) begin
        if (reset_n) begin
            if (mem_write) begin
                wr_cycles    <= wr_cycles + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
            end
            if (mem_read)  rd_cycles <= rd_cycles + 1;
            if (mem_write && mem_read) both_high <= both_high + 1;
        end
    end

    // Slave model: stalls the first stall_target cycles of each request
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (stall_cnt < stall_target) begin
                mem_waitrequest = 1'b1;
                stall_cnt       = stall_cnt + 1;
            end else begin
                mem_waitrequest = 1'b0;
            end
        end else begin
            mem_waitrequest = 1'b0;
            stall_cnt       = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] ir, input logic [1:0] op, input logic [31:0] data);
        @(negedge clk);
        jdo             = {op, 4'h0, data};
        ir_in           = ir;
        jtag_udr_toggle = ~jtag_udr_toggle;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        repeat (6) @(negedge clk);
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        reset_n         = 1'b0;
        jtag_udr_toggle = 1'b0;
        ir_in           = 2'b01;
        jdo             = 38'h0;
        mem_rdata       = 32'h0;
        mem_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr",  32'(mem_addr),  32'h0);
        check("rst_write", 32'(mem_write), 32'h0);
        check("rst_read",  32'(mem_read),  32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_error", 32'(error),     32'h0);
        check("rst_ready", 32'(mon_ready), 32'h0);
        check("rst_dreg",  mon_dreg,       32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait write after SETADDR
        issue(2'b00, 2'b00, 32'h10);
        wait_idle("sa1_idle", 10);
        check("sa1_addr", 32'(mem_addr), 32'h10);
        wr_base = wr_cycles;
        issue(2'b00, 2'b01, 32'hDEADBEEF);
        wait_idle("wr1_idle", 10);
        check("wr1_cycles", 32'(wr_cycles - wr_base), 32'd1);
        check("wr1_waddr",  32'(last_wr_addr), 32'h10);
        check("wr1_wdata",  last_wr_data, 32'hDEADBEEF);
        check("wr1_addr",   32'(mem_addr), 32'h11);

        // Read with 3 wait cycles, then peek
        issue(2'b00, 2'b00, 32'h10);
        wait_idle("sa2_idle", 10);
        mem_rdata    = 32'hCAFEF00D;
        stall_target = 3;
        rd_base      = rd_cycles;
        issue(2'b00, 2'b10, 32'h0);
        wait_idle("rd1_idle", 20);
        check("rd1_cycles", 32'(rd_cycles - rd_base), 32'd4);
        check("rd1_dreg",   mon_dreg, 32'hCAFEF00D);
        check("rd1_ready",  32'(mon_ready), 32'h1);
        check("rd1_addr",   32'(mem_addr), 32'h11);
        mem_rdata    = 32'h12345678;
        stall_target = 0;
        issue(2'b00, 2'b11, 32'h0);
        wait_idle("pk_idle", 20);
        check("pk_addr", 32'(mem_addr), 32'h11);
        check("pk_dreg", mon_dreg, 32'h12345678);

        // Address wrap
        issue(2'b00, 2'b00, 32'hFF);
        wait_idle("sa3_idle", 10);
        issue(2'b00, 2'b01, 32'h1);
        wait_idle("wr2_idle", 10);
        check("wrap_waddr", 32'(last_wr_addr), 32'hFF);
        check("wrap_addr",  32'(mem_addr), 32'h00);

        // Write timeout, then SETADDR clears error
        issue(2'b00, 2'b00, 32'h20);
        wait_idle("sa4_idle", 10);
        stall_target = 1000;
        wr_base      = wr_cycles;
        issue(2'b00, 2'b01, 32'h55);
        wait_idle("tmo_idle", 200);
        check("tmo_cycles", 32'(wr_cycles - wr_base), 32'd64);
        check("tmo_error",  32'(error), 32'h1);
        check("tmo_addr",   32'(mem_addr), 32'h20);
        stall_target = 0;
        issue(2'b00, 2'b00, 32'h30);
        wait_idle("sa5_idle", 10);
        check("clr_error", 32'(error), 32'h0);
        check("clr_addr",  32'(mem_addr), 32'h30);

        // Overrun during a stalled read
        issue(2'b00, 2'b00, 32'h40);
        wait_idle("sa6_idle", 10);
        mem_rdata    = 32'hA5A50001;
        stall_target = 20;
        rd_base      = rd_cycles;
        issue(2'b00, 2'b10, 32'h0);
        repeat (8) @(negedge clk);
        issue(2'b00, 2'b10, 32'h0);
        wait_idle("ovr_idle", 60);
        repeat (6) @(negedge clk);
        stall_target = 0;
        check("ovr_error",  32'(error), 32'h1);
        check("ovr_dreg",   mon_dreg, 32'hA5A50001);
        check("ovr_addr",   32'(mem_addr), 32'h41);
        check("ovr_cycles", 32'(rd_cycles - rd_base), 32'd21);
        check("ovr_busy",   32'(busy), 32'h0);

        // Non-zero IR is ignored
        issue(2'b00, 2'b00, 32'h40);
        wait_idle("sa7_idle", 10);
        wr_base = wr_cycles;
        rd_base = rd_cycles;
        issue(2'b01, 2'b01, 32'h99);
        repeat (10) @(negedge clk);
        check("ign_bus",   32'((wr_cycles - wr_base) + (rd_cycles - rd_base)), 32'd0);
        check("ign_error", 32'(error), 32'h0);
        check("ign_busy",  32'(busy), 32'h0);
        check("ign_addr",  32'(mem_addr), 32'h40);

        // Reset asserted mid-write
        issue(2'b00, 2'b00, 32'h50);
        wait_idle("sa8_idle", 10);
        stall_target = 1000;
        issue(2'b00, 2'b01, 32'h66);
        for (int i = 0; i < 20 && !mem_write; i++) @(negedge clk);
        check("mid_wr_seen", 32'(mem_write), 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_write", 32'(mem_write), 32'h0);
        check("mid_rst_busy",  32'(busy), 32'h0);
        check("mid_rst_addr",  32'(mem_addr), 32'h0);
        jtag_udr_toggle = 1'b0;
        stall_target    = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(2'b00, 2'b00, 32'h60);
        wait_idle("sa9_idle", 10);
        wr_base = wr_cycles;
        issue(2'b00, 2'b01, 32'h77);
        wait_idle("wr3_idle", 10);
        check("post_cycles", 32'(wr_cycles - wr_base), 32'd1);
        check("post_waddr",  32'(last_wr_addr), 32'h60);
        check("post_wdata",  last_wr_data, 32'h77);
        check("post_addr",   32'(mem_addr), 32'h61);
        check("post_error",  32'(error), 32'h0);

        check("rd_wr_exclusive", 32'(both_high), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
